// File: rtl/fft_pkg.sv
// Shared types for the FFT result reader: reader FSM states and the bin payload
// carried through the skid buffer.
package fft_pkg;

  // Payload fields are sized for the widest supported core; users narrow them.
  localparam int unsigned BIN_DW = 32;
  localparam int unsigned BIN_NW = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_FIN      = 3'd3,
    ST_WAIT_CLR = 3'd4
  } reader_state_t;

  typedef struct packed {
    logic signed [BIN_DW-1:0] re;
    logic signed [BIN_DW-1:0] im;
    logic        [BIN_NW-1:0] index;
    logic                     last;
  } fft_bin_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO of FFT bins with a synchronous flush; head is visible
// combinationally from the storage registers.
module skid_fifo2
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       push_i,
  input  fft_bin_t   push_data_i,
  input  logic       pop_i,
  output fft_bin_t   head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  fft_bin_t   mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push_c;
  logic       pop_c;

  assign pop_c  = pop_i && (count_q != 2'd0);
  // A push into a full FIFO is only accepted when the head leaves this cycle.
  assign push_c = push_i && ((count_q != 2'd2) || pop_c);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push_c) - 2'(pop_c);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/fft_result_reader.sv
// Drains one completed FFT frame over the core's DMA read port and streams the
// bins out with index, last flag and the frame's block exponent.
module fft_result_reader
  import fft_pkg::*;
#(
  parameter int unsigned FFT_LENGTH = 1024,
  parameter int unsigned FFT_DW     = 16,
  parameter int unsigned NUM_BINS   = FFT_LENGTH / 2,
  parameter int unsigned FFT_N      = $clog2(FFT_LENGTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     done,
  input  logic signed [7:0]        bfpexp,
  output logic                     fin,
  output logic                     dmaact,
  output logic        [FFT_N-1:0]  dmaa,
  input  logic signed [FFT_DW-1:0] dmadr_real,
  input  logic signed [FFT_DW-1:0] dmadr_imag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [FFT_DW-1:0] out_real,
  output logic signed [FFT_DW-1:0] out_imag,
  output logic        [FFT_N-1:0]  out_index,
  output logic signed [7:0]        out_bfpexp,
  output logic                     out_last
);

  localparam logic [FFT_N-1:0] LAST_IDX = FFT_N'(NUM_BINS - 1);

  reader_state_t     state_q, state_d;
  logic [FFT_N-1:0]  addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic [FFT_N-1:0]  fl_idx_q, fl_idx_d;
  logic signed [7:0] exp_q, exp_d;
  logic              fin_q, fin_d;

  logic              issue_c;
  logic              flush_c;
  logic              pop_c;
  logic              room_c;
  fft_bin_t          push_bin_c;
  fft_bin_t          head_c;
  logic              fifo_full_c;
  logic              fifo_empty_c;
  logic [1:0]        fifo_count_c;
  logic              unused_c;

  assign pop_c  = !fifo_empty_c && out_ready;
  // Buffered plus in-flight bins may never exceed the two FIFO slots.
  assign room_c = ((3'(fifo_count_c) + 3'(inflight_q)) <= 3'd1) || pop_c;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    exp_d   = exp_q;
    fin_d   = 1'b0;
    issue_c = 1'b0;
    flush_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (done) begin
          state_d = ST_READ;
          addr_d  = '0;
          exp_d   = bfpexp;
        end
      end
      ST_READ: begin
        if (!done) begin
          state_d = ST_IDLE;
          flush_c = 1'b1;
        end else if (room_c) begin
          issue_c = 1'b1;
          if (addr_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + FFT_N'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!done) begin
          state_d = ST_IDLE;
          flush_c = 1'b1;
        end else if (!inflight_q &&
                     (fifo_empty_c || (fifo_count_c == 2'd1 && pop_c))) begin
          state_d = ST_FIN;
          fin_d   = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (!done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    inflight_d = issue_c;
    fl_idx_d   = issue_c ? addr_q : fl_idx_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      fl_idx_q   <= '0;
      exp_q      <= '0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      fl_idx_q   <= fl_idx_d;
      exp_q      <= exp_d;
      fin_q      <= fin_d;
    end
  end

  // Read data is valid one cycle after the strobe and is captured unconditionally.
  always_comb begin
    push_bin_c       = '0;
    push_bin_c.re    = BIN_DW'(dmadr_real);
    push_bin_c.im    = BIN_DW'(dmadr_imag);
    push_bin_c.index = BIN_NW'(fl_idx_q);
    push_bin_c.last  = (fl_idx_q == LAST_IDX);
  end

  skid_fifo2 u_skid (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush_c),
    .push_i      (inflight_q),
    .push_data_i (push_bin_c),
    .pop_i       (pop_c),
    .head_o      (head_c),
    .full_o      (fifo_full_c),
    .empty_o     (fifo_empty_c),
    .count_o     (fifo_count_c)
  );

  assign fin        = fin_q;
  assign dmaact     = issue_c;
  assign dmaa       = addr_q;
  assign out_valid  = !fifo_empty_c;
  assign out_real   = FFT_DW'(head_c.re);
  assign out_imag   = FFT_DW'(head_c.im);
  assign out_index  = FFT_N'(head_c.index);
  assign out_last   = !fifo_empty_c && head_c.last;
  assign out_bfpexp = exp_q;

  // Upper payload bits and the full flag are not needed at this width.
  assign unused_c = ^{head_c, fifo_full_c};

endmodule

// File: tb/tb_fft_result_reader.sv
// Randomised and directed bench for fft_result_reader (16-point FFT, 8 bins)
// checked against a frame-level behavioural model.
module tb_fft_result_reader;

  localparam int NB = 8;
  localparam int P_IDLE = 0;
  localparam int P_ACT  = 1;
  localparam int P_DONE = 2;

  logic              clk;
  logic              reset;
  logic              done;
  logic signed [7:0] bfpexp;
  logic              fin;
  logic              dmaact;
  logic [3:0]        dmaa;
  logic signed [15:0] dmadr_real;
  logic signed [15:0] dmadr_imag;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] out_real;
  logic signed [15:0] out_imag;
  logic [3:0]        out_index;
  logic signed [7:0] out_bfpexp;
  logic              out_last;

  int checks = 0;
  int errors = 0;

  fft_result_reader #(
    .FFT_LENGTH (16),
    .FFT_DW     (16),
    .NUM_BINS   (NB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .done       (done),
    .bfpexp     (bfpexp),
    .fin        (fin),
    .dmaact     (dmaact),
    .dmaa       (dmaa),
    .dmadr_real (dmadr_real),
    .dmadr_imag (dmadr_imag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .out_index  (out_index),
    .out_bfpexp (out_bfpexp),
    .out_last   (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DMA memory: real = 3*addr, imag = -addr, one cycle after the strobe.
  always @(posedge clk) begin
    if (dmaact) begin
      dmadr_real <= 16'(int'(dmaa) * 3);
      dmadr_imag <= 16'(-int'(dmaa));
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ready driver: 0 fixed, 1 pattern 1,0,0,1, 2 random.
  int ready_mode = 0;
  bit ready_fixed = 1'b0;
  initial begin
    int pat;
    pat = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          out_ready = (pat == 0) || (pat == 3);
          pat = (pat + 1) % 4;
        end
        2: out_ready = 1'(($urandom >> 3) & 1);
        default: out_ready = ready_fixed;
      endcase
    end
  end

  // Frame-level model state.
  int phase = P_IDLE;
  int rd_cnt = 0, xfer_cnt = 0, age = 0, done_age = 0, cyc = 0;
  int first_cyc = 0, first_age = 0, fin_seen = 0, dmaact_total = 0, last_cnt = 0;
  bit all_ready = 1'b0;
  int exp_m = 0;
  int seen_real[16], seen_imag[16], seen_exp[16];

  always @(negedge clk) begin : model_check
    bit xfer;
    int idx;
    cyc++;
    if (fin) fin_seen++;
    if (dmaact) dmaact_total++;
    if (!reset) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_fin", fin, 0);
      chk("rst_dmaact", dmaact, 0);
      chk("rst_last", out_last, 0);
      chk("rst_dmaa", dmaa, 0);
      chk("rst_index", out_index, 0);
      chk("rst_real", out_real, 0);
      chk("rst_imag", out_imag, 0);
      chk("rst_exp", out_bfpexp, 0);
      phase = P_IDLE;
    end else begin
      xfer = out_valid && out_ready;
      if (phase == P_ACT) begin
        chk("act_fin", fin, 0);
        if (age == 0 && done) begin
          chk("lat_dmaact", dmaact, 1);
          chk("lat_dmaa", dmaa, 0);
        end
        if (age < 2) chk("lat_early_valid", out_valid, 0);
        if (age == 2) chk("lat_valid", out_valid, 1);
        if (!done) chk("abort_dmaact", dmaact, 0);
        if (out_valid) begin
          chk("bin_index", out_index, xfer_cnt);
          chk("bin_real", out_real, 3 * xfer_cnt);
          chk("bin_imag", out_imag, -xfer_cnt);
          chk("bin_last", out_last, longint'(xfer_cnt == NB - 1));
          chk("bin_exp", out_bfpexp, exp_m);
        end
        if (dmaact) begin
          chk("rd_addr", dmaa, rd_cnt);
          chk("rd_bound", longint'(rd_cnt < NB), 1);
          chk("outstanding", longint'((rd_cnt + 1 - xfer_cnt - int'(xfer)) <= 2), 1);
        end
      end else begin
        chk("idle_dmaact", dmaact, 0);
        chk("idle_valid", out_valid, 0);
        chk("fin_pulse", fin, longint'(phase == P_DONE && done_age == 0));
      end
      case (phase)
        P_IDLE: begin
          if (done) begin
            phase = P_ACT;
            exp_m = int'(bfpexp);
            rd_cnt = 0; xfer_cnt = 0; age = 0; last_cnt = 0;
            all_ready = 1'b1;
            for (int i = 0; i < 16; i++) begin
              seen_real[i] = 999; seen_imag[i] = 999; seen_exp[i] = 999;
            end
          end
        end
        P_ACT: begin
          if (!done) begin
            phase = P_IDLE;
          end else begin
            if (!out_ready) all_ready = 1'b0;
            if (dmaact) rd_cnt++;
            if (xfer) begin
              idx = int'(out_index);
              seen_real[idx] = int'(out_real);
              seen_imag[idx] = int'(out_imag);
              seen_exp[idx]  = int'(out_bfpexp);
              if (out_last) last_cnt++;
              if (xfer_cnt == 0) begin
                first_cyc = cyc;
                first_age = age;
              end
              xfer_cnt++;
              if (xfer_cnt == NB) begin
                if (all_ready) chk("burst_len", cyc - first_cyc, NB - 1);
                phase = P_DONE;
                done_age = 0;
              end
            end
            age++;
          end
        end
        default: begin
          if (!done && done_age > 0) phase = P_IDLE;
          done_age++;
        end
      endcase
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_consumed(input int bound);
    int n;
    n = 0;
    while (phase != P_DONE && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_fin", longint'(phase == P_DONE), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fins0, acts0, n;
    reset = 1'b0; done = 1'b0; bfpexp = '0;
    cycles(3);
    reset = 1'b1;
    cycles(2);

    // Ready held high; exponent changes mid-frame; done held after fin.
    ready_mode = 0; ready_fixed = 1'b1;
    bfpexp = -8'sd3; done = 1'b1;
    fins0 = fin_seen; acts0 = dmaact_total;
    cycles(5);
    bfpexp = 8'sd5;
    wait_consumed(100);
    chk("s1_first_age", first_age, 2);
    chk("s1_real0", seen_real[0], 0);
    chk("s1_real5", seen_real[5], 15);
    chk("s1_real7", seen_real[7], 21);
    chk("s1_imag3", seen_imag[3], -3);
    chk("s1_exp0", seen_exp[0], -3);
    chk("s1_exp7", seen_exp[7], -3);
    chk("s1_last_cnt", last_cnt, 1);
    cycles(20);
    chk("s1_fin_cnt", fin_seen - fins0, 1);
    chk("s1_reads", dmaact_total - acts0, 8);
    done = 1'b0;
    cycles(3);

    // Ready pattern 1,0,0,1.
    ready_mode = 1; bfpexp = 8'sd7; done = 1'b1;
    wait_consumed(200);
    chk("s2_real6", seen_real[6], 18);
    chk("s2_exp4", seen_exp[4], 7);
    done = 1'b0;
    cycles(3);

    // Random ready and exponents.
    for (int f = 0; f < 4; f++) begin
      ready_mode = 2;
      bfpexp = 8'($urandom);
      done = 1'b1;
      cycles(2 + int'($urandom_range(0, 6)));
      bfpexp = 8'($urandom);
      wait_consumed(300);
      cycles(int'($urandom_range(0, 5)));
      done = 1'b0;
      cycles(2 + int'($urandom_range(0, 3)));
    end

    // Abort after three transfers.
    ready_mode = 0; ready_fixed = 1'b1; bfpexp = 8'sd1; done = 1'b1;
    fins0 = fin_seen;
    n = 0;
    while (xfer_cnt < 3 && n < 100) begin
      cycles(1);
      n++;
    end
    chk("s4_reach3", longint'(xfer_cnt >= 3), 1);
    done = 1'b0;
    cycles(1);
    chk("s4_valid_drop", out_valid, 0);
    cycles(4);
    chk("s4_no_fin", fin_seen - fins0, 0);
    bfpexp = 8'sd2; done = 1'b1;
    wait_consumed(100);
    chk("s4_restart_real0", seen_real[0], 0);
    chk("s4_restart_exp", seen_exp[0], 2);
    done = 1'b0;
    cycles(3);

    // Reset mid-frame with the FIFO full.
    ready_fixed = 1'b0; bfpexp = 8'sd4; done = 1'b1;
    cycles(8);
    chk("s5_full_valid", out_valid, 1);
    chk("s5_head_idx", out_index, 0);
    reset = 1'b0;
    #1;
    chk("s5_rst_valid", out_valid, 0);
    chk("s5_rst_dmaa", dmaa, 0);
    chk("s5_rst_exp", out_bfpexp, 0);
    chk("s5_rst_dmaact", dmaact, 0);
    cycles(2);
    reset = 1'b1; ready_fixed = 1'b1;
    wait_consumed(100);
    chk("s5_real7", seen_real[7], 21);
    chk("s5_exp", seen_exp[7], 4);
    done = 1'b0;
    cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
